dyn_character_s02: RTL

DYN_CHARACTER_S02 -- requirements
Module: dyn_character_s02

---
 rtl/dyn_character_s02.sv | 118 +++++++++++
 1 files changed

// File: rtl/dyn_character_s02.sv
// Character overlay stage 02: composes one font-ROM glyph row onto the pixel stream,
// with optional frame-based blinking. Stream layout: XC[25:16] YC[15:6] RGB[5:3] HS[2] VS[1] Active[0].
module dyn_character_s02 #(
    parameter logic [2:0]  color_fg     = 3'b110,
    parameter logic [2:0]  color_bg     = 3'b001,
    parameter int unsigned gsize        = 16,
    parameter logic        alpha        = 1'b1,
    parameter int unsigned blink_frames = 32
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic [25:0] RGBStr_i,
    input  logic [9:0]  posx_i,
    input  logic [9:0]  posy_i,
    input  logic [7:0]  data_rom,
    input  logic        blink_en,
    output logic [25:0] RGBStr_o,
    output logic [9:0]  posx_o,
    output logic [9:0]  posy_o,
    output logic        hit
);

    localparam int unsigned PSW     = gsize >> 3;
    localparam int unsigned SDIV    = (PSW > 1) ? $clog2(PSW) : 0;
    localparam logic [10:0] GSZ     = 11'(gsize);
    localparam logic [9:0]  BF_LAST = 10'(blink_frames - 1);
    localparam int unsigned VS_BIT  = 1;
    localparam int unsigned ACT_BIT = 0;

    logic [25:0] r_str_a;
    logic [9:0]  r_posx_a;
    logic [9:0]  r_posy_a;
    logic        r_vs_prev;
    logic [9:0]  r_cnt;
    logic        r_phase;

    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_inbox;
    logic [2:0]  w_gx;
    logic        w_bit;
    logic        w_visible;
    logic        w_vs_rise;
    logic [2:0]  w_rgb;
    logic        w_hit;

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_str_a  <= '0;
            r_posx_a <= '0;
            r_posy_a <= '0;
        end else begin
            r_str_a  <= RGBStr_i;
            r_posx_a <= posx_i;
            r_posy_a <= posy_i;
        end
    end

    // Offsets wrap in 10 bits, so pixels left of/above the origin land far outside the box.
    assign w_dx      = r_str_a[25:16] - r_posx_a;
    assign w_dy      = r_str_a[15:6] - r_posy_a;
    assign w_inbox   = ({1'b0, w_dx} < GSZ) && ({1'b0, w_dy} < GSZ);
    assign w_gx      = 3'(w_dx >> SDIV);
    assign w_bit     = data_rom[3'd7 - w_gx];
    assign w_visible = ~blink_en | r_phase;

    always_comb begin
        w_rgb = r_str_a[5:3];
        w_hit = 1'b0;
        if (r_str_a[ACT_BIT] && w_inbox) begin
            if (w_bit && w_visible) begin
                w_rgb = color_fg;
                w_hit = 1'b1;
            end else if (!alpha) begin
                w_rgb = color_bg;
            end
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            RGBStr_o <= '0;
            posx_o   <= '0;
            posy_o   <= '0;
            hit      <= 1'b0;
        end else begin
            RGBStr_o <= {r_str_a[25:6], w_rgb, r_str_a[2:0]};
            posx_o   <= r_posx_a;
            posy_o   <= r_posy_a;
            hit      <= w_hit;
        end
    end

    // Frame edges are taken from the raw input stream, ahead of the pixel pipeline.
    assign w_vs_rise = RGBStr_i[VS_BIT] & ~r_vs_prev;

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_vs_prev <= 1'b0;
            r_cnt     <= '0;
            r_phase   <= 1'b1;
        end else begin
            r_vs_prev <= RGBStr_i[VS_BIT];
            if (!blink_en) begin
                r_cnt   <= '0;
                r_phase <= 1'b1;
            end else if (w_vs_rise) begin
                if (r_cnt == BF_LAST) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 10'd1;
                end
            end
        end
    end

endmodule
